// File: rtl/register_file_pairs_pkg.sv
// Shared types and constants for the paired-register CPU register file.
// Register and pair select encodings match the decoder's field layout.
package register_file_pairs_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned FLAG_W   = 4;
    localparam int unsigned FLAG_Z   = 3;
    localparam int unsigned FLAG_N   = 2;
    localparam int unsigned FLAG_H   = 1;
    localparam int unsigned FLAG_C   = 0;

    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5,
        REG_F = 3'd6,
        REG_A = 3'd7
    } reg8_sel_t;

    typedef enum logic [1:0] {
        PAIR_BC = 2'd0,
        PAIR_DE = 2'd1,
        PAIR_HL = 2'd2,
        PAIR_SP = 2'd3
    } pair_sel_t;

    // High byte of a pair; the SP encoding maps to AF for byte-addressed pair writes.
    function automatic reg8_sel_t pair_hi(input pair_sel_t p);
        case (p)
            PAIR_BC: pair_hi = REG_B;
            PAIR_DE: pair_hi = REG_D;
            PAIR_HL: pair_hi = REG_H;
            default: pair_hi = REG_A;
        endcase
    endfunction

    function automatic reg8_sel_t pair_lo(input pair_sel_t p);
        case (p)
            PAIR_BC: pair_lo = REG_C;
            PAIR_DE: pair_lo = REG_E;
            PAIR_HL: pair_lo = REG_L;
            default: pair_lo = REG_F;
        endcase
    endfunction

endpackage

// File: rtl/register_file_pairs_if.sv
// Control/read bus between the decoder/control FSM (master) and the register file (slave).
interface register_file_pairs_if #(
    parameter int unsigned DW = 8
);
    import register_file_pairs_pkg::*;

    logic              wr8_en;
    reg8_sel_t         wr8_sel;
    logic [DW-1:0]     wr8_data;
    logic              wr16_en;
    pair_sel_t         wr16_sel;
    logic              wr16_af;
    logic [2*DW-1:0]   wr16_data;
    logic              idu_en;
    logic              idu_dec;
    pair_sel_t         idu_sel;
    logic [FLAG_W-1:0] flags_we;
    logic [FLAG_W-1:0] flags_in;
    reg8_sel_t         rd_selA;
    reg8_sel_t         rd_selB;
    logic [DW-1:0]     rd_outA;
    logic [DW-1:0]     rd_outB;
    pair_sel_t         rd16_sel;
    logic [2*DW-1:0]   rd16_out;
    logic [2*DW-1:0]   sp;
    logic [FLAG_W-1:0] flags;
    logic [8*DW-1:0]   window;

    modport master (
        output wr8_en, wr8_sel, wr8_data,
        output wr16_en, wr16_sel, wr16_af, wr16_data,
        output idu_en, idu_dec, idu_sel,
        output flags_we, flags_in,
        output rd_selA, rd_selB, rd16_sel,
        input  rd_outA, rd_outB, rd16_out, sp, flags, window
    );

    modport slave (
        input  wr8_en, wr8_sel, wr8_data,
        input  wr16_en, wr16_sel, wr16_af, wr16_data,
        input  idu_en, idu_dec, idu_sel,
        input  flags_we, flags_in,
        input  rd_selA, rd_selB, rd16_sel,
        output rd_outA, rd_outB, rd16_out, sp, flags, window
    );

endinterface

// File: rtl/register_file_pairs_reg_next_state.sv
// Combinational next-state for all registers: applies wr8, IDU, wr16 and flag
// updates in ascending priority so later assignments win on overlapping bytes.
module reg_next_state
    import register_file_pairs_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [NUM_REGS-1:0][DW-1:0] regs_cur,
    input  logic [2*DW-1:0]             sp_cur,
    input  logic                        wr8_en,
    input  reg8_sel_t                   wr8_sel,
    input  logic [DW-1:0]               wr8_data,
    input  logic                        wr16_en,
    input  pair_sel_t                   wr16_sel,
    input  logic                        wr16_af,
    input  logic [2*DW-1:0]             wr16_data,
    input  logic                        idu_en,
    input  logic                        idu_dec,
    input  pair_sel_t                   idu_sel,
    input  logic [FLAG_W-1:0]           flags_we,
    input  logic [FLAG_W-1:0]           flags_in,
    output logic [NUM_REGS-1:0][DW-1:0] regs_nxt,
    output logic [2*DW-1:0]             sp_nxt
);

    logic [2*DW-1:0] idu_old;
    logic [2*DW-1:0] idu_new;

    // IDU operand is always the registered pair value, never a same-cycle write.
    always_comb begin
        idu_old = '0;
        if (idu_sel == PAIR_SP) begin
            idu_old = sp_cur;
        end else begin
            idu_old = {regs_cur[pair_hi(idu_sel)], regs_cur[pair_lo(idu_sel)]};
        end
        idu_new = idu_dec ? (idu_old - (2*DW)'(1)) : (idu_old + (2*DW)'(1));
    end

    always_comb begin
        regs_nxt = regs_cur;
        sp_nxt   = sp_cur;

        if (wr8_en) begin
            regs_nxt[wr8_sel] = wr8_data;
        end

        if (idu_en) begin
            if (idu_sel == PAIR_SP) begin
                sp_nxt = idu_new;
            end else begin
                regs_nxt[pair_hi(idu_sel)] = idu_new[2*DW-1:DW];
                regs_nxt[pair_lo(idu_sel)] = idu_new[DW-1:0];
            end
        end

        // Pair select 3 targets SP unless wr16_af redirects it to AF.
        if (wr16_en) begin
            if ((wr16_sel == PAIR_SP) && !wr16_af) begin
                sp_nxt = wr16_data;
            end else begin
                regs_nxt[pair_hi(wr16_sel)] = wr16_data[2*DW-1:DW];
                regs_nxt[pair_lo(wr16_sel)] = wr16_data[DW-1:0];
            end
        end

        // Flags live in the top nibble of F; per-bit enables override everything.
        for (int i = 0; i < int'(FLAG_W); i++) begin
            if (flags_we[i]) begin
                regs_nxt[REG_F][DW-FLAG_W+i] = flags_in[i];
            end
        end

        for (int i = 0; i < int'(DW - FLAG_W); i++) begin
            regs_nxt[REG_F][i] = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_pairs.sv
// GameBoy CPU register file with 16-bit pair access, IDU, per-flag enables and
// optional same-cycle write-to-read bypass.
module register_file_pairs
    import register_file_pairs_pkg::*;
#(
    parameter int unsigned     DW       = 8,
    parameter bit              BYPASS   = 1'b1,
    parameter logic [2*DW-1:0] RESET_SP = 16'hFFFE,
    parameter logic [DW-1:0]   RESET_A  = 8'h01
) (
    input logic                 clk,
    input logic                 rst,
    register_file_pairs_if.slave bus
);

    logic [NUM_REGS-1:0][DW-1:0] regs_q;
    logic [NUM_REGS-1:0][DW-1:0] regs_nxt;
    logic [NUM_REGS-1:0][DW-1:0] rd_src;
    logic [2*DW-1:0]             sp_q;
    logic [2*DW-1:0]             sp_nxt;
    logic [2*DW-1:0]             sp_src;

    reg_next_state #(
        .DW (DW)
    ) u_next (
        .regs_cur  (regs_q),
        .sp_cur    (sp_q),
        .wr8_en    (bus.wr8_en),
        .wr8_sel   (bus.wr8_sel),
        .wr8_data  (bus.wr8_data),
        .wr16_en   (bus.wr16_en),
        .wr16_sel  (bus.wr16_sel),
        .wr16_af   (bus.wr16_af),
        .wr16_data (bus.wr16_data),
        .idu_en    (bus.idu_en),
        .idu_dec   (bus.idu_dec),
        .idu_sel   (bus.idu_sel),
        .flags_we  (bus.flags_we),
        .flags_in  (bus.flags_in),
        .regs_nxt  (regs_nxt),
        .sp_nxt    (sp_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q        <= '0;
            regs_q[REG_A] <= RESET_A;
            sp_q          <= RESET_SP;
        end else begin
            regs_q <= regs_nxt;
            sp_q   <= sp_nxt;
        end
    end

    // Bypass is suppressed during reset so reads show the reset values.
    always_comb begin
        rd_src = regs_q;
        sp_src = sp_q;
        if (BYPASS && !rst) begin
            rd_src = regs_nxt;
            sp_src = sp_nxt;
        end
    end

    always_comb begin
        bus.rd_outA  = rd_src[bus.rd_selA];
        bus.rd_outB  = rd_src[bus.rd_selB];
        bus.rd16_out = sp_src;
        if (bus.rd16_sel != PAIR_SP) begin
            bus.rd16_out = {rd_src[pair_hi(bus.rd16_sel)], rd_src[pair_lo(bus.rd16_sel)]};
        end
    end

    assign bus.sp     = sp_q;
    assign bus.flags  = regs_q[REG_F][DW-1 -: FLAG_W];
    assign bus.window = {regs_q[REG_L], regs_q[REG_H], regs_q[REG_F], regs_q[REG_E],
                         regs_q[REG_D], regs_q[REG_C], regs_q[REG_B], regs_q[REG_A]};

endmodule

// File: doc/register_file_pairs.md
Name: register_file_pairs

Overview:
Second-generation CPU register file for the GameBoy core. Holds A, F, B, C, D, E, H, L and SP. Adds the following over the first generation:
- 16-bit pair read and write (BC, DE, HL, SP/AF).
- A dedicated increment/decrement unit (IDU) for HL+/HL-, INC rr/DEC rr and PUSH/POP SP adjust.
- Per-flag write enables.
- Optional write-to-read bypass.
It sits between the decoder/control FSM and the ALU/address mux.

Parameters:
DW, 8, register width; pairs are 2*DW.
BYPASS, 1, 1 = reads return this cycle's write data; 0 = reads return registered state only.
RESET_SP, 16'hFFFE, SP value after reset (width 2*DW).
RESET_A, 8'h01, A value after reset.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr8_en  in  1  8-bit write strobe
wr8_sel  in  3  0=B 1=C 2=D 3=E 4=H 5=L 6=F 7=A
wr8_data  in  DW  8-bit write data
wr16_en  in  1  pair write strobe
wr16_sel  in  2  0=BC 1=DE 2=HL 3=SP
wr16_af  in  1  when set with wr16_sel=3, target is AF instead of SP
wr16_data  in  2*DW  pair write data
idu_en  in  1  increment/decrement pair
idu_dec  in  1  1 = decrement, 0 = increment
idu_sel  in  2  0=BC 1=DE 2=HL 3=SP
flags_we  in  4  per-flag enable, bit3=Z bit2=N bit1=H bit0=C
flags_in  in  4  new flag values
rd_selA, rd_selB  in  3  8-bit read selects, same encoding as wr8_sel
rd_outA, rd_outB  out  DW  8-bit read data
rd16_sel  in  2  pair read select, same encoding as wr16_sel (3 = SP)
rd16_out  out  2*DW  pair read data
sp  out  2*DW  current SP
flags  out  4  {Z,N,H,C}
window  out  8*DW  {L,H,F,E,D,C,B,A} for debug

Behaviour:
Reset (async, rst high):
- A=RESET_A; B, C, D, E, H, L = 0; F = 0; SP = RESET_SP.
- All outputs reflect these values combinationally while rst is held.
- Reset asserted mid-write discards the write.

Register format:
- F is stored as {Z,N,H,C,4'b0}.
- Low nibble of F always reads 0, whatever is written via wr8 or AF.

Write timing:
- All writes take effect on posedge clk when rst is low, so latency to the registered state is 1 cycle.

Write priority, resolved per byte when sources overlap in one cycle (highest first):
1. flags_we bits, applied per flag bit over any other write to F.
2. wr16.
3. IDU.
4. wr8.

Non-overlapping targets all update in the same cycle. Example: wr8 to A, wr16 to DE and IDU on HL in one cycle update all three.

IDU:
- Target pair gets pair ± 1, modulo 2^(2*DW).
- Wrap: FFFF+1 = 0000 and 0000-1 = FFFF.
- Does not touch flags.
- A carry out of the low byte propagates into the high byte in the same cycle.

Reads:
- rd_outA, rd_outB and rd16_out are combinational.
- BYPASS=1: a read of a register being written this cycle returns the post-priority next value, including IDU results and flag merges. Implemented as mux from next-state logic; no extra cycle.
- BYPASS=0: reads return current registered value.

Other outputs:
- sp, flags and window always show registered state (no bypass).

Decode rules:
- wr16_af has no effect unless wr16_sel=3.
- rd16_sel=3 always reads SP; AF is read via two 8-bit reads.

Decomposition:
- Shared package (constants.sv): typedef reg8_sel_t (3-bit enum B..A as above), typedef pair_sel_t (BC, DE, HL, SP), localparam flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0.
- One sub-module: reg_next_state, purely combinational. It computes the next values of all registers from the write/IDU/flag inputs and priority rules. The top module instantiates it once, registers its outputs, and reuses them for bypass.

Test Plan:
1. Reset: pulse rst mid-cycle with wr8_en=1 -> A=01, F=00, SP=FFFE, others 00; the pending write is lost.
2. HL+ wrap: wr16 HL=00FF, then idu_en inc on HL -> HL=0100; set HL=FFFF then inc -> 0000; dec from 0000 -> FFFF; flags unchanged.
3. Same-cycle conflict: wr8 H=12 and wr16 HL=ABCD -> HL=ABCD. wr8 C=55 with IDU inc BC from 00FF -> BC=0100, and wr8 loses on C.
4. Flag masking: F=F0, wr16 AF=3C0F with flags_we=0100 and flags_in=0000 -> A=3C, F=00 (Z,H,C from data bits 7,5,4 = 0,0,0; N forced 0); low nibble stays 0.
5. Bypass: BYPASS=1, wr8 E=77 with rd_selA=E in the same cycle -> rd_outA=77 that cycle. With BYPASS=0 the same stimulus gives the old E value, then 77 next cycle.
6. SP vs AF: wr16_sel=3, wr16_af=0, data C000 -> SP=C000 and AF unchanged. Repeat with wr16_af=1, data 12FF -> A=12, F=F0, SP unchanged.
